// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the F/D/E/W pipeline.
//
// Produces the per-stage update codes (00 hold, 01 advance, 10 flush/bubble)
// for fdreg, dereg and ewreg, plus the PC enable and redirect select.
// Resolves multi-cycle E waits, load-use hazards, taken redirects from E,
// stop/halt, and external I/O stalls.
//
// Optional feature: define PIPE_CTRL_PERF_EN to build the cycle and stall
// performance counters; otherwise perf_* are tied to zero.
//
// Ports:
//   clk, rstn       clock, asynchronous active-low reset
//   io_stall        external memory/UART not ready; freezes everything
//   resume          one-cycle pulse that leaves HALT
//   de_wait_time    extra E cycles needed by the instruction in E
//   de_stop         instruction in E is a stop
//   de_is_load      instruction in E is a load
//   de_rw, de_rd    E destination bank/write-enable and register
//   d_rs, d_rt      D sources, bit 5 = bank
//   e_redirect      E resolved a taken branch/jump/jr this cycle
//   fd/de/ew_update stage register update codes
//   pc_en           PC may load its next value
//   pc_redirect     PC takes the E target instead of pc+4
//   halted          core is in HALT
//   perf_cycles     non-reset cycle count
//   perf_stalls     cycles with fd_update != advance

module pipe_ctrl #(
    parameter int unsigned WAIT_W = 5,
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              io_stall,
    input  logic              resume,
    input  logic [WAIT_W-1:0] de_wait_time,
    input  logic              de_stop,
    input  logic              de_is_load,
    input  logic [1:0]        de_rw,
    input  logic [4:0]        de_rd,
    input  logic [5:0]        d_rs,
    input  logic [5:0]        d_rt,
    input  logic              e_redirect,
    output logic [1:0]        fd_update,
    output logic [1:0]        de_update,
    output logic [1:0]        ew_update,
    output logic              pc_en,
    output logic              pc_redirect,
    output logic              halted,
    output logic [PERF_W-1:0] perf_cycles,
    output logic [PERF_W-1:0] perf_stalls
);

    localparam int unsigned UPD_W = 2;

    localparam logic [UPD_W-1:0] UPD_HOLD  = 2'b00;
    localparam logic [UPD_W-1:0] UPD_ADV   = 2'b01;
    localparam logic [UPD_W-1:0] UPD_FLUSH = 2'b10;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_WAIT    = 2'd1,
        S_RELEASE = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] cnt;
    logic [WAIT_W-1:0] cnt_nxt;

    logic              rs_match;
    logic              rt_match;
    logic              load_use;

    // Load-use: E writes a register that D reads (bank and index both match).
    always_comb begin
        rs_match = (de_rw[1] == d_rs[5]) && (de_rd == d_rs[4:0]);
        rt_match = (de_rw[1] == d_rt[5]) && (de_rd == d_rt[4:0]);
        load_use = de_is_load && (de_rw != 2'b00) && (rs_match || rt_match);
    end

    // State and wait counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and stage control.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        fd_update   = UPD_HOLD;
        de_update   = UPD_HOLD;
        ew_update   = UPD_HOLD;
        pc_en       = 1'b0;
        pc_redirect = 1'b0;
        halted      = 1'b0;

        if (rstn) begin
            halted = (state == S_HALT);

            if (io_stall) begin
                // Whole pipeline frozen; state and counter keep their values.
                state_nxt = state;
            end else begin
                case (state)
                    S_HALT: begin
                        ew_update = UPD_FLUSH;
                        if (resume) begin
                            state_nxt = S_RUN;
                        end
                    end

                    S_WAIT: begin
                        ew_update = UPD_FLUSH;
                        if (cnt != '0) begin
                            cnt_nxt = cnt - WAIT_W'(1);
                        end
                        if (cnt <= WAIT_W'(1)) begin
                            state_nxt = S_RELEASE;
                        end
                    end

                    S_RUN, S_RELEASE: begin
                        if ((state == S_RUN) && (de_wait_time != '0)) begin
                            // Hold E for de_wait_time cycles; the last held
                            // cycle hands off to RELEASE.
                            ew_update = UPD_FLUSH;
                            cnt_nxt   = de_wait_time - WAIT_W'(1);
                            state_nxt = (de_wait_time == WAIT_W'(1)) ? S_RELEASE : S_WAIT;
                        end else begin
                            state_nxt = S_RUN;
                            if (de_stop) begin
                                // Stop retires, younger stages squashed.
                                fd_update = UPD_FLUSH;
                                de_update = UPD_FLUSH;
                                ew_update = UPD_ADV;
                                state_nxt = S_HALT;
                            end else if (e_redirect) begin
                                // Redirect beats load-use: D is squashed anyway.
                                fd_update   = UPD_FLUSH;
                                de_update   = UPD_FLUSH;
                                ew_update   = UPD_ADV;
                                pc_en       = 1'b1;
                                pc_redirect = 1'b1;
                            end else if (load_use) begin
                                // One bubble into E while F/D hold.
                                fd_update = UPD_HOLD;
                                de_update = UPD_FLUSH;
                                ew_update = UPD_ADV;
                            end else begin
                                fd_update = UPD_ADV;
                                de_update = UPD_ADV;
                                ew_update = UPD_ADV;
                                pc_en     = 1'b1;
                            end
                        end
                    end

                    default: begin
                        state_nxt = S_RUN;
                    end
                endcase
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Free-running cycle and front-end stall counters, wrapping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            perf_cycles <= perf_cycles + PERF_W'(1);
            if (fd_update != UPD_ADV) begin
                perf_stalls <= perf_stalls + PERF_W'(1);
            end
        end
    end
`else
    assign perf_cycles = '0;
    assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed test of pipe_ctrl with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled 1 ns later.

module tb_pipe_ctrl;

    localparam int unsigned WAIT_W = 5;
    localparam int unsigned PERF_W = 32;

    logic              clk;
    logic              rstn;
    logic              io_stall;
    logic              resume;
    logic [WAIT_W-1:0] de_wait_time;
    logic              de_stop;
    logic              de_is_load;
    logic [1:0]        de_rw;
    logic [4:0]        de_rd;
    logic [5:0]        d_rs;
    logic [5:0]        d_rt;
    logic              e_redirect;
    logic [1:0]        fd_update;
    logic [1:0]        de_update;
    logic [1:0]        ew_update;
    logic              pc_en;
    logic              pc_redirect;
    logic              halted;
    logic [PERF_W-1:0] perf_cycles;
    logic [PERF_W-1:0] perf_stalls;

    int tests_run;
    int tests_failed;

    logic [PERF_W-1:0] snap_cycles;
    logic [PERF_W-1:0] snap_stalls;

    pipe_ctrl #(
        .WAIT_W (WAIT_W),
        .PERF_W (PERF_W)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .io_stall     (io_stall),
        .resume       (resume),
        .de_wait_time (de_wait_time),
        .de_stop      (de_stop),
        .de_is_load   (de_is_load),
        .de_rw        (de_rw),
        .de_rd        (de_rd),
        .d_rs         (d_rs),
        .d_rt         (d_rt),
        .e_redirect   (e_redirect),
        .fd_update    (fd_update),
        .de_update    (de_update),
        .ew_update    (ew_update),
        .pc_en        (pc_en),
        .pc_redirect  (pc_redirect),
        .halted       (halted),
        .perf_cycles  (perf_cycles),
        .perf_stalls  (perf_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare the full control word against the expected values.
    task automatic expect_out(input string tag, input logic [1:0] fd, input logic [1:0] de,
                              input logic [1:0] ew, input logic pe, input logic pr,
                              input logic hl);
        check_eq({tag, ".fd"},     32'(fd_update),   32'(fd));
        check_eq({tag, ".de"},     32'(de_update),   32'(de));
        check_eq({tag, ".ew"},     32'(ew_update),   32'(ew));
        check_eq({tag, ".pc_en"},  32'(pc_en),       32'(pe));
        check_eq({tag, ".redir"},  32'(pc_redirect), 32'(pr));
        check_eq({tag, ".halted"}, 32'(halted),      32'(hl));
    endtask

    task automatic clear_in();
        io_stall     = 1'b0;
        resume       = 1'b0;
        de_wait_time = '0;
        de_stop      = 1'b0;
        de_is_load   = 1'b0;
        de_rw        = 2'b00;
        de_rd        = 5'd0;
        d_rs         = 6'd0;
        d_rt         = 6'd0;
        e_redirect   = 1'b0;
    endtask

    // Advance to the next falling edge with all inputs idle.
    task automatic next_cycle();
        @(negedge clk);
        clear_in();
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rstn         = 1'b0;
        clear_in();

        // Reset: every output forced to zero.
        #3;
        expect_out("rst", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        check_eq("rst.perf_cycles", perf_cycles, 32'd0);
        check_eq("rst.perf_stalls", perf_stalls, 32'd0);
        @(negedge clk);
        @(negedge clk);

        // Idle run: advance every cycle.
        rstn = 1'b1;
        settle();
        expect_out("idle0", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
        next_cycle(); settle();
        expect_out("idle1", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0);

        // Wait time 3: three hold cycles, then advance despite wait_time=3.
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            de_wait_time = 5'd3;
            settle();
            if (i < 3) expect_out($sformatf("wait3_c%0d", i), 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
            else       expect_out("wait3_rel", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
        end
        next_cycle(); settle();
        expect_out("wait3_run", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0);

        // Wait time 1: single hold then advance.
        next_cycle(); de_wait_time = 5'd1; settle();
        expect_out("wait1_hold", 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
        next_cycle(); de_wait_time = 5'd1; settle();
        expect_out("wait1_rel", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0);

        // Load-use on d_rt, same bank: one bubble.
        next_cycle();
        de_is_load = 1'b1; de_rw = 2'b01; de_rd = 5'd5; d_rt = 6'd5;
        settle();
        expect_out("lu_rt", 2'b00, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0);

        // Same register index, other bank: no hazard.
        next_cycle();
        de_is_load = 1'b1; de_rw = 2'b01; de_rd = 5'd5; d_rt = 6'd37;
        settle();
        expect_out("lu_bank1", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0);

        // Load-use via d_rs into bank 1.
        next_cycle();
        de_is_load = 1'b1; de_rw = 2'b10; de_rd = 5'd0; d_rs = 6'd32;
        settle();
        expect_out("lu_rs_r0", 2'b00, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0);

        // Load that does not write: no hazard.
        next_cycle();
        de_is_load = 1'b1; de_rw = 2'b00; de_rd = 5'd5; d_rt = 6'd5;
        settle();
        expect_out("lu_nowrite", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0);

        // Redirect beats load-use.
        next_cycle();
        de_is_load = 1'b1; de_rw = 2'b01; de_rd = 5'd5; d_rt = 6'd5; e_redirect = 1'b1;
        settle();
        expect_out("redir_lu", 2'b10, 2'b10, 2'b01, 1'b1, 1'b1, 1'b0);

        // Resume outside HALT is ignored.
        next_cycle(); resume = 1'b1; settle();
        expect_out("resume_run", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0);

        // Stop, then HALT until the resume pulse.
        next_cycle(); de_stop = 1'b1; settle();
        expect_out("stop", 2'b10, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0);
        next_cycle(); settle();
        expect_out("halt0", 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1);
        next_cycle(); io_stall = 1'b1; resume = 1'b1; settle();
        expect_out("halt_io", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        next_cycle(); resume = 1'b1; settle();
        expect_out("halt_resume", 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1);
        next_cycle(); settle();
        expect_out("post_resume", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0);

        // Stop with wait time 2: wait first, stop taken in RELEASE.
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            de_wait_time = 5'd2; de_stop = 1'b1;
            settle();
            if (i < 2) expect_out($sformatf("wstop_c%0d", i), 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
            else       expect_out("wstop_rel", 2'b10, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0);
        end
        next_cycle(); resume = 1'b1; settle();
        expect_out("wstop_halt", 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1);
        next_cycle(); settle();
        expect_out("wstop_run", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0);

        // Wait time 4 with a 2-cycle I/O stall in the middle: 6 hold cycles.
        next_cycle();
        snap_cycles = perf_cycles;
        snap_stalls = perf_stalls;
        de_wait_time = 5'd4;
        settle();
        expect_out("io_w0", 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
        next_cycle(); de_wait_time = 5'd4; settle();
        expect_out("io_w1", 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            next_cycle(); de_wait_time = 5'd4; io_stall = 1'b1; settle();
            expect_out($sformatf("io_stall%0d", i), 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            next_cycle(); de_wait_time = 5'd4; settle();
            expect_out($sformatf("io_w%0d", i + 2), 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
        end
        next_cycle(); de_wait_time = 5'd4; settle();
        expect_out("io_rel", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
        check_eq("perf_stalls_delta", perf_stalls - snap_stalls, 32'd6);
        check_eq("perf_cycles_delta", perf_cycles - snap_cycles, 32'd6);
`else
        check_eq("perf_stalls_off", perf_stalls, 32'd0);
        check_eq("perf_cycles_off", perf_cycles, 32'd0);
`endif

        // I/O stall during plain RUN, then advance resumes.
        next_cycle(); io_stall = 1'b1; settle();
        expect_out("io_run", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        next_cycle(); settle();
        expect_out("io_run_after", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-run zeroes outputs immediately.
        rstn = 1'b0;
        settle();
        expect_out("rst_async", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
